cdc_hs_tx: RTL and testbench

Source-domain transmitter for a four-phase req/ack bundled-data handshake that carries a DATA_W-bit word into an asynchronous destination clock domain. It accepts a word on a valid/ready interface and drives a level request with the payload held stable. The returning acknowledge is resynchronised through an internal three-stage synchroniser before the next word is accepted. It is paired with a destination-side receiver that synchronises `tx_req`, captures `tx_data` and drives `ack_async`.

---
 rtl/cdc_pkg.sv | 14 +
 rtl/cdc_sync_ah.sv | 25 ++
 rtl/cdc_hs_tx.sv | 117 +++++++++++
 tb/tb_cdc_hs_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and constants for the
// req/ack bundled-data CDC transmitter.
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      ACK_LO = 2'd2
   } cdc_state_t;

   localparam int CDC_SYNC_STAGES = 3;
   localparam int CDC_TMO_W       = 16;

endpackage

// File: rtl/cdc_sync_ah.sv
// cdc_sync_ah: single-bit flop-chain synchroniser,
// asynchronous active-high reset to 0.
module cdc_sync_ah
   import cdc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [CDC_SYNC_STAGES-1:0] ff_q;

   // shift the async input through the chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_q <= '0;
      end else begin
         ff_q <= {ff_q[CDC_SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff_q[CDC_SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: four-phase req/ack source-side transmitter.
// Optional ack-timeout flag: CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_req,
   output logic [DATA_W-1:0] tx_data,
   input  logic              ack_async,
   output logic              done,
   output logic              busy,
   output logic              timeout_err
);

   cdc_state_t        state_q;
   cdc_state_t        state_d;
   logic              ack_s;
   logic              run_q;
   logic              tx_req_q;
   logic              done_q;
   logic [DATA_W-1:0] data_q;
   logic              load;

   cdc_sync_ah u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_async),
      .q   (ack_s)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: accept, wait ack high, wait ack low
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load)   state_d = REQ_HI;
         REQ_HI:  if (ack_s)  state_d = ACK_LO;
         ACK_LO:  if (!ack_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from the state register;
   // run_q keeps in_ready low until the first edge out of reset
   always_comb begin
      in_ready = (state_q == IDLE) && run_q;
      busy     = (state_q != IDLE);
      load     = in_ready && in_valid;
   end

   // registered request, payload and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q    <= 1'b0;
         tx_req_q <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         run_q    <= 1'b1;
         tx_req_q <= (state_d == REQ_HI);
         done_q   <= (state_q == ACK_LO)
                  && (state_d == IDLE);
         if (load) begin
            data_q <= in_data;
         end
      end
   end

   assign tx_req  = tx_req_q;
   assign tx_data = data_q;
   assign done    = done_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam logic [CDC_TMO_W-1:0] TMO_LIM =
      CDC_TMO_W'(TIMEOUT_CYCLES);

   logic [CDC_TMO_W-1:0] tmo_cnt_q;
   logic                 tmo_q;

   // wait-cycle counter; flag is sticky, FSM keeps waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else if (state_d != state_q) begin
         tmo_cnt_q <= '0;
      end else if (busy && (tmo_cnt_q != '1)) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (tmo_cnt_q == TMO_LIM - 1'b1) begin
            tmo_q <= 1'b1;
         end
      end
   end

   assign timeout_err = tmo_q;
`else
   logic unused_tmo;
   assign unused_tmo  = (TIMEOUT_CYCLES != 0);
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed self-checking bench with a
// scoreboard of accepted words checked at the responder.
module tb_cdc_hs_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        tx_req;
   logic [31:0] tx_data;
   logic        ack_async;
   logic        done;
   logic        busy;
   logic        timeout_err;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic        resp_en = 1'b0;
   logic        prev_req = 1'b0;
   logic [31:0] held = '0;
   logic [31:0] sb[$];

   cdc_hs_tx #(
      .DATA_W         (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .tx_req      (tx_req),
      .tx_data     (tx_data),
      .ack_async   (ack_async),
      .done        (done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // done pulse counter; in_ready must be up with done
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         chk("rdy_on_done", {63'd0, in_ready}, 64'd1);
      end
   end

   // payload must not move while the request is up
   always @(negedge clk) begin
      if (tx_req === 1'b1 && prev_req === 1'b1)
         chk("data_hold", {32'd0, tx_data}, {32'd0, held});
      if (tx_req === 1'b1 && prev_req !== 1'b1)
         held = tx_data;
      prev_req = tx_req;
   end

   // destination model: ack 2 cycles after req, drop 2 after req falls
   initial begin
      int          n;
      logic [31:0] exp;
      ack_async = 1'b0;
      forever begin
         tick();
         if (resp_en && tx_req) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 64'd1, 64'd0);
               exp = '0;
            end else begin
               exp = sb.pop_front();
            end
            chk("rx_data", {32'd0, tx_data}, {32'd0, exp});
            repeat (2) tick();
            ack_async = 1'b1;
            n = 0;
            while (tx_req && n < 20) begin
               tick();
               n++;
            end
            // 3 edges through the synchroniser, 4th edge drops req
            chk("req_fall", 64'(n), 64'd4);
            repeat (2) tick();
            ack_async = 1'b0;
         end
      end
   end

   initial begin
      int n;
      int base;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      #2;
      chk("rst_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_req", {63'd0, tx_req}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_data", {32'd0, tx_data}, 64'd0);
      chk("rst_tmo", {63'd0, timeout_err}, 64'd0);
      repeat (3) tick();
      rst = 1'b0;
      chk("rel_ready0", {63'd0, in_ready}, 64'd0);
      tick();
      chk("rel_ready1", {63'd0, in_ready}, 64'd1);

      // single transfer
      resp_en  = 1'b1;
      in_data  = 32'hA5A5_0001;
      sb.push_back(in_data);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("s_req", {63'd0, tx_req}, 64'd1);
      chk("s_busy", {63'd0, busy}, 64'd1);
      chk("s_ready", {63'd0, in_ready}, 64'd0);
      chk("s_data", {32'd0, tx_data}, 64'hA5A5_0001);
      n = 0;
      while (done_cnt < 1 && n < 60) begin
         tick();
         n++;
      end
      chk("s_done_wait", {63'd0, done_cnt >= 1}, 64'd1);
      repeat (5) tick();
      chk("s_done_cnt", 64'(done_cnt), 64'd1);
      chk("s_idle_ready", {63'd0, in_ready}, 64'd1);
      chk("s_idle_data", {32'd0, tx_data}, 64'hA5A5_0001);

      // back-to-back words 1, 2, 3
      base     = done_cnt;
      in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 32'(i);
         sb.push_back(in_data);
         n = 0;
         while (!in_ready && n < 60) begin
            tick();
            n++;
         end
         chk("b2b_ready", {63'd0, in_ready}, 64'd1);
         tick();
         chk("b2b_acc", {32'd0, tx_data}, 64'(i));
         chk("b2b_busy", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      n = 0;
      while (done_cnt < base + 3 && n < 100) begin
         tick();
         n++;
      end
      repeat (5) tick();
      chk("b2b_done_cnt", 64'(done_cnt - base), 64'd3);
      chk("b2b_sb_left", 64'(sb.size()), 64'd0);
      chk("b2b_last", {32'd0, tx_data}, 64'd3);

      // early ack: request lasts one cycle, done waits for ack low
      resp_en   = 1'b0;
      ack_async = 1'b1;
      repeat (5) tick();
      base     = done_cnt;
      in_data  = 32'h0000_E001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("e_req1", {63'd0, tx_req}, 64'd1);
      tick();
      chk("e_req0", {63'd0, tx_req}, 64'd0);
      chk("e_busy", {63'd0, busy}, 64'd1);
      repeat (10) tick();
      chk("e_no_done", 64'(done_cnt - base), 64'd0);
      chk("e_still_busy", {63'd0, busy}, 64'd1);
      ack_async = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      // 3 synchroniser edges, 4th edge leaves ACK_LO
      chk("e_done_lat", 64'(n), 64'd4);

      // no ack: timeout flag behaviour
      repeat (3) tick();
      in_data  = 32'h0000_7001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (15) tick();
      chk("t_pre", {63'd0, timeout_err}, 64'd0);
      tick();
`ifdef CDC_HS_TX_TIMEOUT_EN
      chk("t_set", {63'd0, timeout_err}, 64'd1);
`else
      chk("t_off16", {63'd0, timeout_err}, 64'd0);
`endif
      repeat (50) tick();
      chk("t_req_hold", {63'd0, tx_req}, 64'd1);
      base      = done_cnt;
      ack_async = 1'b1;
      n = 0;
      while (tx_req && n < 20) begin
         tick();
         n++;
      end
      chk("t_req_fall", {63'd0, tx_req}, 64'd0);
      ack_async = 1'b0;
      n = 0;
      while (done_cnt == base && n < 20) begin
         tick();
         n++;
      end
      chk("t_done", 64'(done_cnt - base), 64'd1);
`ifdef CDC_HS_TX_TIMEOUT_EN
      chk("t_sticky", {63'd0, timeout_err}, 64'd1);
`else
      chk("t_off_end", {63'd0, timeout_err}, 64'd0);
`endif

      // reset in the middle of a transfer
      repeat (2) tick();
      in_data  = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("r_req_pre", {63'd0, tx_req}, 64'd1);
      chk("r_data_pre", {32'd0, tx_data}, 64'hDEAD_BEEF);
      #2;
      rst = 1'b1;
      #1;
      chk("r_req", {63'd0, tx_req}, 64'd0);
      chk("r_data", {32'd0, tx_data}, 64'd0);
      chk("r_busy", {63'd0, busy}, 64'd0);
      chk("r_ready", {63'd0, in_ready}, 64'd0);
      chk("r_tmo", {63'd0, timeout_err}, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("r_rel_ready", {63'd0, in_ready}, 64'd1);
      chk("r_rel_req", {63'd0, tx_req}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
